clk_period_monitor: RTL and testbench



---
 rtl/clk_mon_pkg.sv | 22 ++
 rtl/sync_edge_det.sv | 36 +++
 rtl/clk_period_monitor.sv | 125 ++++++++++++
 tb/tb_clk_period_monitor.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_mon_pkg.sv
// Shared state encoding and window helper for the slow-clock period monitor.
// Optional duty-cycle measurement in clk_period_monitor is enabled by DUTY_MEAS_EN.
package clk_mon_pkg;

  localparam int CNT_W_DEFAULT = 28;

  typedef logic [1:0] mon_state_t;

  localparam mon_state_t ST_IDLE    = 2'd0;
  localparam mon_state_t ST_MEASURE = 2'd1;
  localparam mon_state_t ST_LOST    = 2'd2;

  // Inclusive window around center; the lower bound clamps at zero instead of wrapping.
  function automatic logic within_tol(input logic [63:0] value,
                                      input logic [63:0] center,
                                      input logic [63:0] tol);
    logic [63:0] lo;
    lo = (center > tol) ? center - tol : 64'd0;
    return (value >= lo) && (value <= center + tol);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level plus single-cycle edge pulses.
// The fall pulse exists only when DUTY_MEAS_EN is defined.
module sync_edge_det (
  input  logic clk100Mhz,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
`ifdef DUTY_MEAS_EN
  ,
  output logic fall
`endif
);

  logic syncMeta;
  logic syncOut;
  logic syncPrev;

  always_ff @(posedge clk100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      syncMeta <= 1'b0;
      syncOut  <= 1'b0;
      syncPrev <= 1'b0;
    end else begin
      syncMeta <= async_in;
      syncOut  <= syncMeta;
      syncPrev <= syncOut;
    end
  end

  assign rise = syncOut & ~syncPrev;

`ifdef DUTY_MEAS_EN
  assign fall = ~syncOut & syncPrev;
`endif

endmodule

// File: rtl/clk_period_monitor.sv
// Measures the period of an asynchronous slow clock and reports tolerance, lock and loss.
// Define DUTY_MEAS_EN to add the high_time / duty_ok outputs.
module clk_period_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEFAULT,
  parameter int EXP_PERIOD = 1000,
  parameter int TOL        = 4,
  parameter int TIMEOUT    = 2000,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk100Mhz,
  input  logic             rst_n,
  input  logic             slowClk_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             in_tol,
  output logic             locked,
`ifdef DUTY_MEAS_EN
  output logic [CNT_W-1:0] high_time,
  output logic             duty_ok,
`endif
  output logic             lost
);

  localparam int               LOCK_W      = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [LOCK_W-1:0] LOCK_FULL  = LOCK_W'(LOCK_COUNT);

  mon_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [LOCK_W-1:0] lockCnt;
  logic              slowRise;
  logic              cntInTol;

`ifdef DUTY_MEAS_EN
  logic              slowFall;
  logic [CNT_W-1:0]  highCap;
`endif

  sync_edge_det u_sync (
    .clk100Mhz (clk100Mhz),
    .rst_n     (rst_n),
    .async_in  (slowClk_in),
`ifdef DUTY_MEAS_EN
    .fall      (slowFall),
`endif
    .rise      (slowRise)
  );

  assign cntInTol = within_tol(64'(cnt), 64'(EXP_PERIOD), 64'(TOL));

  // cnt holds the number of edges since the last rise; a rise in the same cycle as the timeout wins.
  always_ff @(posedge clk100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      lockCnt      <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      in_tol       <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (slowRise) begin
            cnt   <= CNT_ONE;
            state <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (slowRise) begin
            period       <= cnt;
            period_valid <= 1'b1;
            in_tol       <= cntInTol;
            cnt          <= CNT_ONE;
            if (!cntInTol) begin
              lockCnt <= '0;
            end else if (lockCnt != LOCK_FULL) begin
              lockCnt <= lockCnt + LOCK_W'(1);
            end
          end else if (cnt == CNT_TIMEOUT) begin
            state   <= ST_LOST;
            lockCnt <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_LOST: begin
          if (slowRise) begin
            cnt   <= CNT_ONE;
            state <= ST_MEASURE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign locked = (lockCnt == LOCK_FULL);
  assign lost   = (state == ST_LOST);

`ifdef DUTY_MEAS_EN
  // At a fall, cnt already equals the high time of the current period.
  always_ff @(posedge clk100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      highCap   <= '0;
      high_time <= '0;
      duty_ok   <= 1'b0;
    end else if (state == ST_MEASURE) begin
      if (slowFall) begin
        highCap <= cnt;
      end
      if (slowRise) begin
        high_time <= highCap;
        duty_ok   <= within_tol(64'(highCap), 64'(cnt >> 1), 64'(TOL));
      end
    end
  end
`endif

endmodule

// File: tb/tb_clk_period_monitor.sv
// Randomized self-checking bench for clk_period_monitor against a rise-time based reference model.
// Define DUTY_MEAS_EN to also exercise high_time / duty_ok.
module tb_clk_period_monitor;

  localparam int EXP     = 1000;
  localparam int TOLV    = 4;
  localparam int TIMEOUT = 2000;
  localparam int LOCK    = 4;

  logic        clk100Mhz;
  logic        rst_n;
  logic        slowClk_in;
  logic [27:0] period;
  logic        period_valid;
  logic        in_tol;
  logic        locked;
  logic        lost;
`ifdef DUTY_MEAS_EN
  logic [27:0] high_time;
  logic        duty_ok;
`endif

  clk_period_monitor dut (
    .clk100Mhz    (clk100Mhz),
    .rst_n        (rst_n),
    .slowClk_in   (slowClk_in),
    .period       (period),
    .period_valid (period_valid),
    .in_tol       (in_tol),
    .locked       (locked),
`ifdef DUTY_MEAS_EN
    .high_time    (high_time),
    .duty_ok      (duty_ok),
`endif
    .lost         (lost)
  );

  initial clk100Mhz = 1'b0;
  always #5 clk100Mhz = ~clk100Mhz;

  typedef struct {
    int tick;
    int per;
    bit tol;
    bit lock;
    int high;
    bit duty;
  } meas_t;

  meas_t expQ[$];
  meas_t obsQ[$];

  int checks;
  int errors;
  int tickNo;
  int lostOnTick;
  int lostTicks;
  bit lostPrev;

  bit mHaveRef;
  int mLastRise;
  int mLastFall;
  int mRun;

  // Reference: every measurement is the distance between consecutive driven rises,
  // reported two ticks after the closing rise; gaps beyond TIMEOUT mean loss.
  task automatic model_rise(input int t);
    meas_t m;
    int p;
    if (mHaveRef && (t - mLastRise) <= TIMEOUT) begin
      p      = t - mLastRise;
      m.tick = t + 2;
      m.per  = p;
      m.tol  = (p >= EXP - TOLV) && (p <= EXP + TOLV);
      mRun   = m.tol ? ((mRun < LOCK) ? mRun + 1 : LOCK) : 0;
      m.lock = (mRun == LOCK);
      m.high = mLastFall - mLastRise;
      m.duty = (m.high >= p / 2 - TOLV) && (m.high <= p / 2 + TOLV);
      expQ.push_back(m);
    end else begin
      mRun = 0;
    end
    mHaveRef  = 1'b1;
    mLastRise = t;
  endtask

  task automatic tick(input logic v);
    meas_t o;
    @(negedge clk100Mhz);
    if (v && !slowClk_in) model_rise(tickNo);
    if (!v && slowClk_in) mLastFall = tickNo;
    slowClk_in = v;
    @(posedge clk100Mhz);
    #1;
    if (period_valid === 1'b1) begin
      o.tick = tickNo;
      o.per  = int'(period);
      o.tol  = in_tol;
      o.lock = locked;
`ifdef DUTY_MEAS_EN
      o.high = int'(high_time);
      o.duty = duty_ok;
`else
      o.high = 0;
      o.duty = 1'b0;
`endif
      obsQ.push_back(o);
    end
    if (lost === 1'b1 && !lostPrev && lostOnTick < 0) lostOnTick = tickNo;
    if (lost === 1'b1) lostTicks++;
    lostPrev = (lost === 1'b1);
    tickNo++;
  endtask

  task automatic drive_period(input int hi, input int lo);
    repeat (hi) tick(1'b1);
    repeat (lo) tick(1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk100Mhz);
    #1;
    checks++;
    if (period !== 28'd0) begin
      errors++;
      $display("[TB] FAIL reset_period got %0d want 0", period);
    end
    checks++;
    if (period_valid !== 1'b0 || in_tol !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags got valid=%0b in_tol=%0b want 0 0", period_valid, in_tol);
    end
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_locked got %0b want 0", locked);
    end
    checks++;
    if (lost !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_lost got %0b want 0", lost);
    end
`ifdef DUTY_MEAS_EN
    checks++;
    if (high_time !== 28'd0 || duty_ok !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_duty got high=%0d duty_ok=%0b want 0 0", high_time, duty_ok);
    end
`endif
    @(negedge clk100Mhz);
    rst_n = 1'b1;
    mHaveRef = 1'b0;
    mRun     = 0;
  endtask

  task automatic test_nominal();
    expQ.delete();
    obsQ.delete();
    lostTicks = 0;
    repeat (6) drive_period(500, 500);
    checks++;
    if (obsQ.size() != expQ.size()) begin
      errors++;
      $display("[TB] FAIL nominal_count got %0d want %0d", obsQ.size(), expQ.size());
    end
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      checks++;
      if (obsQ[i].tick !== expQ[i].tick || obsQ[i].per !== expQ[i].per ||
          obsQ[i].tol !== expQ[i].tol || obsQ[i].lock !== expQ[i].lock) begin
        errors++;
        $display("[TB] FAIL nominal_meas%0d got tick=%0d period=%0d in_tol=%0b locked=%0b want tick=%0d period=%0d in_tol=%0b locked=%0b",
                 i, obsQ[i].tick, obsQ[i].per, obsQ[i].tol, obsQ[i].lock,
                 expQ[i].tick, expQ[i].per, expQ[i].tol, expQ[i].lock);
      end
    end
    checks++;
    if (lostTicks != 0 || locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL nominal_status got lost_ticks=%0d locked=%0b want 0 1", lostTicks, locked);
    end
  endtask

  task automatic test_reset_mid();
    repeat (300) tick(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (period !== 28'd0) begin
      errors++;
      $display("[TB] FAIL midreset_period got %0d want 0", period);
    end
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_locked got %0b want 0", locked);
    end
    checks++;
    if (period_valid !== 1'b0 || in_tol !== 1'b0 || lost !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_flags got valid=%0b in_tol=%0b lost=%0b want 0 0 0", period_valid, in_tol, lost);
    end
    slowClk_in = 1'b0;
    repeat (4) @(posedge clk100Mhz);
    @(negedge clk100Mhz);
    rst_n    = 1'b1;
    mHaveRef = 1'b0;
    mRun     = 0;
    expQ.delete();
    obsQ.delete();
    repeat (3) drive_period(500, 500);
    checks++;
    if (obsQ.size() != expQ.size()) begin
      errors++;
      $display("[TB] FAIL midreset_count got %0d want %0d", obsQ.size(), expQ.size());
    end
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      checks++;
      if (obsQ[i].tick !== expQ[i].tick || obsQ[i].per !== expQ[i].per ||
          obsQ[i].tol !== expQ[i].tol || obsQ[i].lock !== expQ[i].lock) begin
        errors++;
        $display("[TB] FAIL midreset_meas%0d got tick=%0d period=%0d in_tol=%0b locked=%0b want tick=%0d period=%0d in_tol=%0b locked=%0b",
                 i, obsQ[i].tick, obsQ[i].per, obsQ[i].tol, obsQ[i].lock,
                 expQ[i].tick, expQ[i].per, expQ[i].tol, expQ[i].lock);
      end
    end
  endtask

  task automatic test_tolerance();
    int plist[11] = '{1000, 1000, 1005, 1000, 1000, 1000, 1000, 996, 1004, 995, 1000};
    expQ.delete();
    obsQ.delete();
    foreach (plist[k]) drive_period(500, plist[k] - 500);
    checks++;
    if (obsQ.size() != expQ.size()) begin
      errors++;
      $display("[TB] FAIL tolerance_count got %0d want %0d", obsQ.size(), expQ.size());
    end
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      checks++;
      if (obsQ[i].tick !== expQ[i].tick || obsQ[i].per !== expQ[i].per ||
          obsQ[i].tol !== expQ[i].tol || obsQ[i].lock !== expQ[i].lock) begin
        errors++;
        $display("[TB] FAIL tolerance_meas%0d got tick=%0d period=%0d in_tol=%0b locked=%0b want tick=%0d period=%0d in_tol=%0b locked=%0b",
                 i, obsQ[i].tick, obsQ[i].per, obsQ[i].tol, obsQ[i].lock,
                 expQ[i].tick, expQ[i].per, expQ[i].tol, expQ[i].lock);
      end
    end
  endtask

  task automatic test_lost();
    int rise2Tick;
    int rise3Tick;
    expQ.delete();
    obsQ.delete();
    lostOnTick = -1;
    drive_period(500, 1500);
    rise2Tick = tickNo;
    drive_period(500, 1501);
    rise3Tick = tickNo;
    repeat (5) tick(1'b1);
    checks++;
    if (lostOnTick != rise2Tick + TIMEOUT + 2) begin
      errors++;
      $display("[TB] FAIL lost_gap2001_onset got tick %0d want %0d", lostOnTick, rise2Tick + TIMEOUT + 2);
    end
    lostOnTick = -1;
    repeat (495) tick(1'b1);
    repeat (2600) tick(1'b0);
    checks++;
    if (lostOnTick != rise3Tick + TIMEOUT + 2) begin
      errors++;
      $display("[TB] FAIL lost_hold_onset got tick %0d want %0d", lostOnTick, rise3Tick + TIMEOUT + 2);
    end
    checks++;
    if (lost !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lost_hold_status got lost=%0b locked=%0b want 1 0", lost, locked);
    end
    repeat (2) drive_period(500, 500);
    checks++;
    if (lost !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lost_recover got lost=%0b want 0", lost);
    end
    checks++;
    if (obsQ.size() != expQ.size()) begin
      errors++;
      $display("[TB] FAIL lost_count got %0d want %0d", obsQ.size(), expQ.size());
    end
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      checks++;
      if (obsQ[i].tick !== expQ[i].tick || obsQ[i].per !== expQ[i].per ||
          obsQ[i].tol !== expQ[i].tol || obsQ[i].lock !== expQ[i].lock) begin
        errors++;
        $display("[TB] FAIL lost_meas%0d got tick=%0d period=%0d in_tol=%0b locked=%0b want tick=%0d period=%0d in_tol=%0b locked=%0b",
                 i, obsQ[i].tick, obsQ[i].per, obsQ[i].tol, obsQ[i].lock,
                 expQ[i].tick, expQ[i].per, expQ[i].tol, expQ[i].lock);
      end
    end
  endtask

  task automatic test_random();
    int p;
    int hi;
    expQ.delete();
    obsQ.delete();
    for (int n = 0; n < 10; n++) begin
      p  = int'($urandom_range(1010, 990));
      hi = int'($urandom_range(p - 100, 100));
      drive_period(hi, p - hi);
    end
    drive_period(500, 500);
    checks++;
    if (obsQ.size() != expQ.size()) begin
      errors++;
      $display("[TB] FAIL random_count got %0d want %0d", obsQ.size(), expQ.size());
    end
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      checks++;
      if (obsQ[i].tick !== expQ[i].tick || obsQ[i].per !== expQ[i].per ||
          obsQ[i].tol !== expQ[i].tol || obsQ[i].lock !== expQ[i].lock) begin
        errors++;
        $display("[TB] FAIL random_meas%0d got tick=%0d period=%0d in_tol=%0b locked=%0b want tick=%0d period=%0d in_tol=%0b locked=%0b",
                 i, obsQ[i].tick, obsQ[i].per, obsQ[i].tol, obsQ[i].lock,
                 expQ[i].tick, expQ[i].per, expQ[i].tol, expQ[i].lock);
      end
    end
  endtask

`ifdef DUTY_MEAS_EN
  task automatic test_duty();
    expQ.delete();
    obsQ.delete();
    repeat (4) drive_period(300, 700);
    repeat (4) drive_period(500, 500);
    checks++;
    if (obsQ.size() != expQ.size()) begin
      errors++;
      $display("[TB] FAIL duty_count got %0d want %0d", obsQ.size(), expQ.size());
    end
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      checks++;
      if (obsQ[i].per !== expQ[i].per || obsQ[i].high !== expQ[i].high ||
          obsQ[i].duty !== expQ[i].duty) begin
        errors++;
        $display("[TB] FAIL duty_meas%0d got period=%0d high=%0d duty_ok=%0b want period=%0d high=%0d duty_ok=%0b",
                 i, obsQ[i].per, obsQ[i].high, obsQ[i].duty,
                 expQ[i].per, expQ[i].high, expQ[i].duty);
      end
    end
  endtask
`endif

  initial begin
    checks     = 0;
    errors     = 0;
    tickNo     = 0;
    lostOnTick = -1;
    lostTicks  = 0;
    lostPrev   = 1'b0;
    mHaveRef   = 1'b0;
    mLastRise  = 0;
    mLastFall  = 0;
    mRun       = 0;
    slowClk_in = 1'b0;
    rst_n      = 1'b0;
    $display("[TB] starting clk_period_monitor bench");
    test_reset();
    test_nominal();
    test_reset_mid();
    test_tolerance();
    test_lost();
    test_random();
`ifdef DUTY_MEAS_EN
    test_duty();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
